// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Receive-side word handshake between uart_rx and its consumer.
//                The receiver (master) presents a word with status flags; the
//                consumer (slave) acknowledges it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int N = 8
);
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         frame_err;
    logic         overrun;
    logic         rx_ack;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ack
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x oversampling UART receiver with majority-vote bit
//                decisions, framing-error / break handling and a one-word
//                holding register with overrun detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int N         = 8,
    parameter int F_MHZ     = 50,
    parameter int BAUD_RATE = 9600
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  rx,
    output logic       busy,
    uart_rx_if.master  bus
);
    // Oversampling tick period in clocks; never allowed to fall below one.
    localparam int TICK_RAW = (F_MHZ * 1000000) / (BAUD_RATE * 16);
    localparam int T_TICK   = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TW       = (T_TICK > 1) ? $clog2(T_TICK) : 1;
    localparam int BW       = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    s;
    logic [BW-1:0] bit_idx;
    logic [N-1:0]  shreg;
    logic          v7;
    logic          v8;

    logic tick;
    logic maj;
    logic complete;
    logic take;

    // Tick fires on the last clock of each oversampling period.
    assign tick     = (tick_cnt == TW'(T_TICK - 1));
    // Bit value: two stored samples (s=7, s=8) voted against the live s=9 one.
    assign maj      = (v7 & v8) | (v7 & rxs) | (v8 & rxs);
    // Frame ends at the stop bit's decision point.
    assign complete = (state == STOP) && tick && (s == 4'd9);
    // A finished word may be loaded if the holder is empty or being freed now.
    assign take     = !bus.rx_valid || bus.rx_ack;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM with tick / sample / bit counters and the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
            s        <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            v7       <= 1'b1;
            v8       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                        s        <= '0;
                    end
                end
                START, DATA, STOP: begin
                    tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                    if (tick) begin
                        s <= s + 4'd1;
                        if (s == 4'd7) v7 <= rxs;
                        if (s == 4'd8) v8 <= rxs;
                        if (state == START) begin
                            if ((s == 4'd9) && maj) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else if (s == 4'd15) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end else if (state == DATA) begin
                            if (s == 4'd9) shreg <= {maj, shreg[N-1:1]};
                            if (s == 4'd15) begin
                                if (bit_idx == BW'(N - 1)) state <= STOP;
                                else bit_idx <= bit_idx + BW'(1);
                            end
                        end else if (s == 4'd9) begin
                            state <= maj ? IDLE : BREAK;
                            busy  <= !maj;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: load, overrun on a full holder, clear on acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else if (complete && take) begin
            bus.rx_data   <= shreg;
            bus.rx_valid  <= 1'b1;
            bus.frame_err <= !maj;
            bus.overrun   <= 1'b0;
        end else if (complete) begin
            bus.overrun   <= 1'b1;
        end else if (bus.rx_valid && bus.rx_ack) begin
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are serialised onto
//                the line; expected words are queued when a frame is issued
//                and a monitor compares them as the receiver presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    localparam int CLK_PER_BIT = 32;   // 1 MHz / 31250 baud

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic busy;

    uart_rx_if #(.N(8)) bus ();

    uart_rx #(.N(8), .F_MHZ(1), .BAUD_RATE(31250)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         start;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic hold_ack   = 1'b0;
    logic model_held = 1'b0;
    logic model_ovr  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    endtask

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: a word lands in the holder unless one is still unacked,
    // in which case it is lost and the overrun flag is expected.
    task automatic model_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        if (model_held) begin
            model_ovr = 1'b1;
        end else begin
            e.data  = d;
            e.ferr  = !stop;
            e.start = cyc;
            sb.push_back(e);
            model_held = hold_ack;
        end
    endtask

    // Serialise start, N data bits LSB first, stop. Optional 2-clock glitch in
    // the middle of one data bit; optional early abort at clock abort_at.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit,
                              input int abort_at, input bit expect_out);
        logic [9:0] bits;
        int         b;
        int         ph;
        bits = {stop, d, 1'b0};
        if (expect_out) model_frame(d, stop);
        for (int k = 0; k < 10 * CLK_PER_BIT; k++) begin
            if (k == abort_at) return;
            b  = k / CLK_PER_BIT;
            ph = k % CLK_PER_BIT;
            rx = bits[b];
            if (glitch_bit >= 0 && b == glitch_bit + 1 && (ph == 18 || ph == 19)) rx = ~bits[b];
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare each presented word against the queue, then acknowledge.
    initial begin : monitor
        exp_t e;
        bit   have;
        bus.rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rx_valid) begin
                have = 1'b0;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: actual rx_data=%0h required=no word", bus.rx_data);
                end else begin
                    e    = sb.pop_front();
                    have = 1'b1;
                    check("rx_data", bus.rx_data, e.data);
                    check("frame_err", bus.frame_err, e.ferr);
                    check_range("latency", cyc - e.start, 300, 320);
                end
                for (int w = 0; w < 5000 && hold_ack; w++) @(negedge clk);
                if (hold_ack) begin
                    n_checks++;
                    $display("FAIL hold_timeout: actual=held required=released");
                end
                check("overrun", bus.overrun, model_ovr);
                if (have) check("data_stable", bus.rx_data, e.data);
                bus.rx_ack = 1'b1;
                @(negedge clk);
                bus.rx_ack = 1'b0;
                model_held = 1'b0;
                model_ovr  = 1'b0;
                check("ack_valid", bus.rx_valid, 0);
                check("ack_ferr", bus.frame_err, 0);
                check("ack_ovr", bus.overrun, 0);
            end
        end
    end

    // Stimulus sequence.
    initial begin : stim
        logic [7:0] d;
        rx    = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.rx_data, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_ovr", bus.overrun, 0);
        clocks(3);
        rst_n = 1'b1;
        clocks(5);

        send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
        clocks(20);

        // False start: 10-clock low pulse.
        rx = 1'b0;
        clocks(6);
        check("false_start_busy_hi", busy, 1);
        clocks(4);
        rx = 1'b1;
        clocks(40);
        check("false_start_busy_lo", busy, 0);
        check("false_start_valid", bus.rx_valid, 0);

        // Framing error followed by a held break.
        send_frame(8'h3C, 1'b0, -1, -1, 1'b1);
        rx = 1'b0;
        clocks(3 * CLK_PER_BIT);
        check("break_busy", busy, 1);
        rx = 1'b1;
        clocks(5);
        check("break_exit_busy", busy, 0);
        send_frame(8'h55, 1'b1, -1, -1, 1'b1);
        clocks(20);

        // Overrun: second word arrives while the first is unacknowledged.
        hold_ack = 1'b1;
        send_frame(8'h11, 1'b1, -1, -1, 1'b1);
        send_frame(8'h22, 1'b1, -1, -1, 1'b1);
        clocks(5);
        hold_ack = 1'b0;
        clocks(20);

        // Randomised traffic.
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, -1, -1, 1'b1);
            clocks($urandom_range(1, 40));
        end

        // Single-sample glitch is voted out.
        send_frame(8'hFF, 1'b1, 3, -1, 1'b1);
        clocks(20);

        // Reset in the middle of data bit 4.
        send_frame(8'h5A, 1'b1, -1, 5 * CLK_PER_BIT + 16, 1'b0);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", bus.rx_valid, 0);
        check("midrst_data", bus.rx_data, 0);
        check("midrst_ferr", bus.frame_err, 0);
        check("midrst_ovr", bus.overrun, 0);
        rx = 1'b1;
        clocks(3);
        rst_n = 1'b1;
        clocks(10);
        send_frame(8'h81, 1'b1, -1, -1, 1'b1);
        clocks(20);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "time limit reached");
    end
endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning data bits per frame.
REQ-002 The block SHALL have parameter F_MHZ, default 50, meaning clk frequency in MHz.
REQ-003 The block SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate.
REQ-004 The block SHALL have port clk, input, 1, system clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_ack, input, 1, consumer acknowledge of held word.
REQ-008 The block SHALL have port rx_data, output, N, received word, LSB first on line.
REQ-009 The block SHALL have port rx_valid, output, 1, rx_data holds an unacknowledged word.
REQ-010 The block SHALL have port frame_err, output, 1, held word had stop bit sampled 0.
REQ-011 The block SHALL have port overrun, output, 1, a frame completed while rx_valid was high.
REQ-012 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer, both flops resetting to 1; all logic uses the synchronized value rxs.
REQ-014 Tick period SHALL be T_TICK = F_MHZ*1000000/(BAUD_RATE*16) clocks, integer division, minimum 1; bit period = 16 ticks.
REQ-015 A sample counter s SHALL count 0..15 per bit on each tick, wrapping 15->0.
REQ-016 Each bit value SHALL be the majority of rxs at s=7, 8 and 9, decided at s=9.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-018 IDLE: rxs=0 SHALL clear the tick counter and s, and enter START.
REQ-019 START: decided bit 1 SHALL be a false start, returning to IDLE with no output change; bit 0 SHALL enter DATA at s=15 wrap.
REQ-020 DATA: N bits SHALL shift into a shift register LSB first; after the Nth bit's s=15 wrap, enter STOP.
REQ-021 STOP: at the s=9 decision, the frame SHALL complete; stop=1 -> IDLE, stop=0 -> BREAK.
REQ-022 BREAK SHALL wait for rxs=1, then enter IDLE; no further frames are received while in BREAK.
REQ-023 On frame completion with rx_valid=0, in the next clock rx_data SHALL load the shift register, rx_valid=1, and frame_err=NOT stop.
REQ-024 On frame completion with rx_valid=1, rx_data and frame_err SHALL be retained, the new word SHALL be discarded, and overrun SHALL be set to 1.
REQ-025 rx_ack=1 while rx_valid=1 SHALL clear rx_valid, frame_err and overrun in the next clock; rx_ack while rx_valid=0 SHALL be ignored.
REQ-026 When completion and rx_ack coincide, the ack SHALL clear the old word and the new word SHALL load with rx_valid=1 and overrun=0.
REQ-027 rx_data SHALL stay stable while rx_valid=1.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, all counters 0, rx_data=0, rx_valid=0, frame_err=0, overrun=0 and busy=0, including mid-frame.
REQ-029 After rst_n rises, the block SHALL wait for rxs=0 in IDLE; a line already low at release SHALL be treated as a start edge.

Verification (F_MHZ=1, BAUD_RATE=31250 -> T_TICK=2, 32 clocks/bit)
REQ-030 Send 0xA5 with stop=1 -> rx_valid=1 about 9.5 bit times after the start edge, rx_data=0xA5, frame_err=0; rx_ack pulse -> rx_valid=0 next clock.
REQ-031 Pulse rx low for 10 clocks -> false start, busy returns to 0, rx_valid stays 0.
REQ-032 Send 0x3C with stop=0, then hold rx low for 3 bit times -> rx_data=0x3C, frame_err=1, busy=1 until rx rises; a following 0x55 frame is received correctly.
REQ-033 Send 0x11 then 0x22 without ack -> rx_data=0x11, overrun=1; ack -> all flags 0.
REQ-034 Inject a 2-clock glitch at s=8 of data bit 3 of 0xFF -> rx_data=0xFF (majority vote).
REQ-035 Assert rst_n=0 during data bit 4 -> outputs return to reset values immediately; the next full frame 0x81 is received correctly.
